// File: rtl/cv32e40p_pkg.sv
// Shared CV32E40P definitions needed by the multiplier request sequencer:
// the multiplier operation encoding.
package cv32e40p_pkg;

    typedef enum logic [2:0] {
        MUL_MAC32 = 3'b000,
        MUL_MSU32 = 3'b001,
        MUL_I     = 3'b010,
        MUL_IR    = 3'b011,
        MUL_DOT8  = 3'b100,
        MUL_DOT16 = 3'b101,
        MUL_H     = 3'b110
    } mul_opcode_e;

endpackage : cv32e40p_pkg

// File: rtl/mul_seq_pkg.sv
// Types shared by the multiplier request sequencer: FSM state encoding and
// the holding-register layout with its reset value.
package mul_seq_pkg;

    import cv32e40p_pkg::*;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } mul_seq_state_e;

    // One captured multiplier request: operation, operands and modifiers.
    typedef struct packed {
        mul_opcode_e op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [1:0]  short_signed;
        logic        short_subword;
        logic [4:0]  imm;
    } mul_req_t;

    localparam mul_req_t MUL_REQ_RESET = '{
        op:            MUL_MAC32,
        a:             32'd0,
        b:             32'd0,
        c:             32'd0,
        short_signed:  2'd0,
        short_subword: 1'b0,
        imm:           5'd0
    };

endpackage : mul_seq_pkg

// File: rtl/mul_req_sequencer_chk.sv
// Protocol checks for the multiplier request sequencer. Purely observational.
module mul_req_sequencer_chk
    import mul_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_ready,
    input  logic        mul_enable,
    input  logic        mul_ready,
    input  logic        mul_multicycle,
    input  logic        mul_ex_ready,
    input  mul_req_t    hold,
    input  logic        rsp_valid,
    input  logic        rsp_ready,
    input  logic [31:0] rsp_result
);

    // Nothing is offered upstream or to the multiplier while in reset.
    a_rst_quiet : assert property (@(posedge clk) rst |-> (!req_ready && !mul_enable))
        else $error("sequencer active during reset");

    // The multiplier only stalls an issued op when it reports a multicycle op.
    a_stall_multicycle : assert property (@(posedge clk) disable iff (rst)
        (mul_enable && !mul_ready) |-> mul_multicycle)
        else $error("multiplier stall without multicycle");

    // Request presented to the multiplier is frozen until it completes.
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (mul_enable && !(mul_ready && mul_ex_ready)) |=> (mul_enable && $stable(hold)))
        else $error("multiplier request changed before completion");

    // A stalled response keeps its value.
    a_rsp_stable : assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result)))
        else $error("stalled response changed");

endmodule : mul_req_sequencer_chk

// File: rtl/mul_rsp_slot.sv
// Single-entry response slot. Holds the multiplier result until the
// downstream consumer takes it, and tells the sequencer whether a new
// result can be written this cycle (ex_ready_o).
module mul_rsp_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        complete_i,
    input  logic [31:0] result_i,
    input  logic        rsp_ready_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_result_o,
    output logic        ex_ready_o
);

    logic        rsp_valid_r;
    logic [31:0] rsp_result_r;

    // Capture a completing result; otherwise drop the entry once it is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 32'd0;
        end else if (complete_i) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= result_i;
        end else if (rsp_valid_r && rsp_ready_i) begin
            rsp_valid_r  <= 1'b0;
        end
    end

    // The slot can accept a new result if it is empty or is being emptied now
    assign ex_ready_o   = ~rsp_valid_r | rsp_ready_i;
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_result_o = rsp_result_r;

endmodule : mul_rsp_slot

// File: rtl/mul_req_sequencer.sv
// Multiplier request sequencer. Accepts one request at a time from upstream,
// presents it to the multiplier until the multiplier reports ready and the
// response slot can take the result, then forwards the result downstream.
// A new request may be accepted in the same cycle the current one completes,
// giving back-to-back issue without a bubble. Also reports the
// issue-to-completion latency of the most recent op (saturating).
module mul_req_sequencer
    import cv32e40p_pkg::*;
    import mul_seq_pkg::*;
#(
    parameter int unsigned LAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  mul_opcode_e       req_op_i,
    input  logic [31:0]       req_a_i,
    input  logic [31:0]       req_b_i,
    input  logic [31:0]       req_c_i,
    input  logic [1:0]        req_short_signed_i,
    input  logic              req_short_subword_i,
    input  logic [4:0]        req_imm_i,

    output logic              mul_enable_o,
    output mul_opcode_e       mul_operator_o,
    output logic [31:0]       mul_operand_a_o,
    output logic [31:0]       mul_operand_b_o,
    output logic [31:0]       mul_operand_c_o,
    output logic [1:0]        mul_short_signed_o,
    output logic              mul_short_subword_o,
    output logic [4:0]        mul_imm_o,
    output logic              mul_ex_ready_o,

    input  logic [31:0]       mul_result_i,
    input  logic              mul_multicycle_i,
    input  logic              mul_ready_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_result_o,

    output logic [LAT_W-1:0]  last_lat_o
);

    localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0] LAT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [LAT_W-1:0] LAT_MAX  = {LAT_W{1'b1}};

    mul_seq_state_e   state_r;
    mul_seq_state_e   state_next_s;
    mul_req_t         hold_r;
    logic             issue_s;
    logic             complete_s;
    logic             req_ready_s;
    logic             accept_s;
    logic             ex_ready_s;
    logic [LAT_W-1:0] lat_cnt_r;
    logic [LAT_W-1:0] last_lat_r;

    // Handshake qualifiers and next-state selection
    always_comb begin
        issue_s      = 1'b0;
        complete_s   = 1'b0;
        req_ready_s  = 1'b0;
        accept_s     = 1'b0;
        state_next_s = state_r;

        issue_s    = (state_r == ISSUE);
        complete_s = issue_s & mul_ready_i & ex_ready_s;

        if (rst) begin
            req_ready_s = 1'b0;
        end else begin
            req_ready_s = ~issue_s | complete_s;
        end
        accept_s = req_valid_i & req_ready_s;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                // A same-cycle accept keeps us issuing with the new request
                if (complete_s && !accept_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Holding register: captured on accept, frozen otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r <= MUL_REQ_RESET;
        end else if (accept_s) begin
            hold_r <= '{
                op:            req_op_i,
                a:             req_a_i,
                b:             req_b_i,
                c:             req_c_i,
                short_signed:  req_short_signed_i,
                short_subword: req_short_subword_i,
                imm:           req_imm_i
            };
        end
    end

    // Latency counter: 1 in the first issue cycle, saturating; sampled on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt_r  <= LAT_ZERO;
            last_lat_r <= LAT_ZERO;
        end else begin
            if (accept_s) begin
                lat_cnt_r <= LAT_ONE;
            end else if (issue_s && (lat_cnt_r != LAT_MAX)) begin
                lat_cnt_r <= lat_cnt_r + LAT_ONE;
            end
            if (complete_s) begin
                last_lat_r <= lat_cnt_r;
            end
        end
    end

    mul_rsp_slot u_rsp_slot (
        .clk          (clk),
        .rst          (rst),
        .complete_i   (complete_s),
        .result_i     (mul_result_i),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_result_o (rsp_result_o),
        .ex_ready_o   (ex_ready_s)
    );

    mul_req_sequencer_chk u_chk (
        .clk            (clk),
        .rst            (rst),
        .req_ready      (req_ready_s),
        .mul_enable     (mul_enable_o),
        .mul_ready      (mul_ready_i),
        .mul_multicycle (mul_multicycle_i),
        .mul_ex_ready   (ex_ready_s),
        .hold           (hold_r),
        .rsp_valid      (rsp_valid_o),
        .rsp_ready      (rsp_ready_i),
        .rsp_result     (rsp_result_o)
    );

    assign req_ready_o         = req_ready_s;
    assign mul_enable_o        = issue_s & ~rst;
    assign mul_operator_o      = hold_r.op;
    assign mul_operand_a_o     = hold_r.a;
    assign mul_operand_b_o     = hold_r.b;
    assign mul_operand_c_o     = hold_r.c;
    assign mul_short_signed_o  = hold_r.short_signed;
    assign mul_short_subword_o = hold_r.short_subword;
    assign mul_imm_o           = hold_r.imm;
    assign mul_ex_ready_o      = ex_ready_s;
    assign last_lat_o          = last_lat_r;

endmodule : mul_req_sequencer
